// File: rtl/i2c_byte_master.sv
`default_nettype none
// ============================================================================
// Module      : i2c_byte_master
// Description : Sends each accepted byte as a single-byte I2C write to a fixed
//               7-bit slave address: START, addr+W, ACK, data, ACK, STOP.
//               SCL/SDA are open-drain; outputs describe release/pull-low.
// Ports       : clk          system clock (rising edge)
//               rst_n        asynchronous active-low reset
//               i_din        byte to transmit
//               i_din_valid  one-clock request, sampled only when idle
//               o_busy       high from accept until done
//               o_done       one-clock pulse at end of frame
//               o_ack_err    an ACK slot read 1; held until next accept
//               o_scl        I2C clock (1 = released)
//               o_sda_oe     1 = pull SDA low, 0 = release
//               i_sda_in     sampled SDA line
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_byte_master #(
    parameter int         CLK_DIV    = 4,
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_din,
    input  logic       i_din_valid,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_ack_err,
    output logic       o_scl,
    output logic       o_sda_oe,
    input  logic       i_sda_in
);

    localparam int             DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0]     C_ADDR_BYTE = {SLAVE_ADDR, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_DATA, S_DACK, S_STOP, S_DONE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_q, w_q_nxt;
    logic [2:0]       r_bit, w_bit_nxt;
    logic [DIV_W-1:0] r_div;
    logic [7:0]       r_shift;
    logic             r_busy, r_done, r_ack_err, r_scl, r_sda_oe;
    logic             w_scl_nxt, w_sda_oe_nxt, w_tx_bit;
    logic             w_accept, w_tick, w_nack;

    assign w_accept = (r_state == S_IDLE) && i_din_valid;
    assign w_tick   = r_busy && (r_div == C_DIV_LAST);
    assign w_nack   = w_tick && (r_q == 2'd2) && i_sda_in &&
                      ((r_state == S_AACK) || (r_state == S_DACK));

    // Next state / quarter / bit counters
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_bit_nxt   = r_bit;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_START;
                    w_q_nxt     = 2'd0;
                    w_bit_nxt   = 3'd0;
                end
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: begin
                if (w_tick) begin
                    w_q_nxt = r_q + 2'd1;
                    if (r_q == 2'd3) begin
                        case (r_state)
                            S_START: w_state_nxt = S_ADDR;
                            S_ADDR: begin
                                w_bit_nxt = r_bit + 3'd1;
                                if (r_bit == 3'd7) w_state_nxt = S_AACK;
                            end
                            // ack_err was captured at this slot's q2 tick and
                            // can only have been set by the address ACK here.
                            S_AACK:  w_state_nxt = r_ack_err ? S_STOP : S_DATA;
                            S_DATA: begin
                                w_bit_nxt = r_bit + 3'd1;
                                if (r_bit == 3'd7) w_state_nxt = S_DACK;
                            end
                            S_DACK:  w_state_nxt = S_STOP;
                            S_STOP:  w_state_nxt = S_DONE;
                            default: w_state_nxt = S_IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    // Line levels are decoded from the *next* state/quarter and registered,
    // so they switch on the same edge as the quarter they belong to.
    assign w_tx_bit = (w_state_nxt == S_ADDR) ? C_ADDR_BYTE[3'd7 - w_bit_nxt]
                                              : r_shift[3'd7 - w_bit_nxt];

    always_comb begin
        w_scl_nxt    = 1'b1;
        w_sda_oe_nxt = 1'b0;
        case (w_state_nxt)
            S_START: begin
                w_scl_nxt    = (w_q_nxt != 2'd3);
                w_sda_oe_nxt = (w_q_nxt >= 2'd2);
            end
            S_ADDR, S_DATA: begin
                w_scl_nxt    = (w_q_nxt == 2'd1) || (w_q_nxt == 2'd2);
                w_sda_oe_nxt = ~w_tx_bit;
            end
            S_AACK, S_DACK: begin
                w_scl_nxt    = (w_q_nxt == 2'd1) || (w_q_nxt == 2'd2);
                w_sda_oe_nxt = 1'b0;
            end
            S_STOP: begin
                w_scl_nxt    = (w_q_nxt != 2'd0);
                w_sda_oe_nxt = (w_q_nxt <= 2'd1);
            end
            default: begin
                w_scl_nxt    = 1'b1;
                w_sda_oe_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_q       <= 2'd0;
            r_bit     <= 3'd0;
            r_div     <= '0;
            r_shift   <= 8'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_scl     <= 1'b1;
            r_sda_oe  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_q      <= w_q_nxt;
            r_bit    <= w_bit_nxt;
            r_scl    <= w_scl_nxt;
            r_sda_oe <= w_sda_oe_nxt;
            r_done   <= (r_state == S_DONE);
            if (w_accept) begin
                r_shift   <= i_din;
                r_busy    <= 1'b1;
                r_ack_err <= 1'b0;
                r_div     <= '0;
            end else begin
                if (r_state == S_DONE) r_busy <= 1'b0;
                if (w_nack) r_ack_err <= 1'b1;
                if (!r_busy || w_tick) r_div <= '0;
                else                   r_div <= r_div + DIV_W'(1);
            end
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_ack_err = r_ack_err;
    assign o_scl     = r_scl;
    assign o_sda_oe  = r_sda_oe;

endmodule
`default_nettype wire

// File: tb/tb_i2c_byte_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_i2c_byte_master
// Description : Directed bench for i2c_byte_master (CLK_DIV=4 and CLK_DIV=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_byte_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din0 = 8'd0, din1 = 8'd0;
    logic       dv0 = 1'b0, dv1 = 1'b0;
    logic [1:0] sda_mode = 2'd0;
    logic       sda0;
    logic       busy0, done0, ackerr0, scl0, oe0;
    logic       busy1, done1, ackerr1, scl1, oe1;

    // bus monitor state
    logic        sel = 1'b0, mon_clr = 1'b0;
    logic        p_scl = 1'b1, p_oe = 1'b0;
    int          nrise = 0, nstart = 0, nstop = 0, nbad = 0;
    logic [31:0] bits = 32'd0;
    logic        m_scl, m_oe;

    int total = 0, bad = 0, lat;

    always #5 clk = ~clk;

    // mode 0: slave ACKs; 1: slave NACKs; 2: ACK address, NACK data
    assign sda0  = (sda_mode == 2'd0) ? 1'b0 :
                   (sda_mode == 2'd1) ? 1'b1 : (nrise >= 10);
    assign m_scl = sel ? scl1 : scl0;
    assign m_oe  = sel ? oe1  : oe0;

    i2c_byte_master #(.CLK_DIV(4), .SLAVE_ADDR(7'h50)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_din(din0), .i_din_valid(dv0),
        .o_busy(busy0), .o_done(done0), .o_ack_err(ackerr0),
        .o_scl(scl0), .o_sda_oe(oe0), .i_sda_in(sda0)
    );

    i2c_byte_master #(.CLK_DIV(1), .SLAVE_ADDR(7'h50)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_din(din1), .i_din_valid(dv1),
        .o_busy(busy1), .o_done(done1), .o_ack_err(ackerr1),
        .o_scl(scl1), .o_sda_oe(oe1), .i_sda_in(1'b0)
    );

    // Records the SDA level at every SCL rise plus START/STOP conditions.
    always @(negedge clk) begin
        if (mon_clr) begin
            nrise <= 0; nstart <= 0; nstop <= 0; nbad <= 0; bits <= 32'd0;
        end else begin
            if (m_scl && !p_scl) begin
                bits  <= {bits[30:0], ~m_oe};
                nrise <= nrise + 1;
            end
            if (m_scl && p_scl && m_oe && !p_oe) nstart <= nstart + 1;
            if (m_scl && p_scl && !m_oe && p_oe) nstop <= nstop + 1;
            if ((m_scl != p_scl) && (m_oe != p_oe)) nbad <= nbad + 1;
        end
        p_scl <= m_scl;
        p_oe  <= m_oe;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input bit d1, input logic [7:0] b, input bit imm);
        if (!imm) begin @(posedge clk); #1; end
        mon_clr = 1'b1;
        sel     = d1;
        if (d1) begin din1 = b; dv1 = 1'b1; end
        else    begin din0 = b; dv0 = 1'b1; end
        @(posedge clk); #1;
        mon_clr = 1'b0; dv0 = 1'b0; dv1 = 1'b0;
    endtask

    task automatic wait_done(input bit d1, input int limit, output int l);
        l = 0;
        for (int n = 1; n <= limit; n++) begin
            @(posedge clk); #1;
            if ((d1 ? done1 : done0) === 1'b1) begin l = n; break; end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy",  {31'd0, busy0},   32'd0);
        chk("rst_done",  {31'd0, done0},   32'd0);
        chk("rst_ackerr",{31'd0, ackerr0}, 32'd0);
        chk("rst_scl",   {31'd0, scl0},    32'd1);
        chk("rst_oe",    {31'd0, oe0},     32'd0);
        chk("rst_scl1",  {31'd0, scl1},    32'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // ACKed write of A5
        sda_mode = 2'd0;
        start_frame(1'b0, 8'hA5, 1'b0);
        chk("acc_busy", {31'd0, busy0}, 32'd1);
        wait_done(1'b0, 400, lat);
        chk("ack_lat",    lat,    32'd321);
        chk("ack_nrise",  nrise,  32'd19);
        chk("ack_bits",   bits,   {13'd0, 8'hA0, 1'b1, 8'hA5, 1'b1, 1'b0});
        chk("ack_start",  nstart, 32'd1);
        chk("ack_stop",   nstop,  32'd1);
        chk("ack_glitch", nbad,   32'd0);
        chk("ack_err",    {31'd0, ackerr0}, 32'd0);
        chk("ack_busy",   {31'd0, busy0},   32'd0);

        // Address NACK
        sda_mode = 2'd1;
        start_frame(1'b0, 8'h77, 1'b0);
        wait_done(1'b0, 400, lat);
        chk("anack_lat",   lat,   32'd177);
        chk("anack_nrise", nrise, 32'd10);
        chk("anack_bits",  bits,  {22'd0, 8'hA0, 1'b1, 1'b0});
        chk("anack_stop",  nstop, 32'd1);
        chk("anack_err",   {31'd0, ackerr0}, 32'd1);

        // Data NACK
        sda_mode = 2'd2;
        start_frame(1'b0, 8'h3C, 1'b0);
        wait_done(1'b0, 400, lat);
        sda_mode = 2'd0;
        chk("dnack_lat",  lat,   32'd321);
        chk("dnack_bits", bits,  {13'd0, 8'hA0, 1'b1, 8'h3C, 1'b1, 1'b0});
        chk("dnack_stop", nstop, 32'd1);
        chk("dnack_err",  {31'd0, ackerr0}, 32'd1);

        // din_valid while busy is ignored
        start_frame(1'b0, 8'h12, 1'b0);
        repeat (60) @(posedge clk);
        #1 din0 = 8'hFF; dv0 = 1'b1;
        @(posedge clk);
        #1 dv0 = 1'b0;
        wait_done(1'b0, 400, lat);
        chk("busy_lat",  lat,  32'd260);
        chk("busy_bits", bits, {13'd0, 8'hA0, 1'b1, 8'h12, 1'b1, 1'b0});
        chk("busy_err",  {31'd0, ackerr0}, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("busy_no2nd",  {31'd0, busy0}, 32'd0);
        chk("busy_nrise",  nrise, 32'd19);

        // Reset during data bit 3 of C3
        start_frame(1'b0, 8'hC3, 1'b0);
        repeat (208) @(posedge clk);
        #1;
        chk("mid_scl_pre",  {31'd0, scl0},  32'd0);
        chk("mid_oe_pre",   {31'd0, oe0},   32'd1);
        chk("mid_busy_pre", {31'd0, busy0}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_scl",    {31'd0, scl0},    32'd1);
        chk("mid_oe",     {31'd0, oe0},     32'd0);
        chk("mid_busy",   {31'd0, busy0},   32'd0);
        chk("mid_ackerr", {31'd0, ackerr0}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        start_frame(1'b0, 8'h5A, 1'b0);
        wait_done(1'b0, 400, lat);
        chk("post_lat",    lat,  32'd321);
        chk("post_bits",   bits, {13'd0, 8'hA0, 1'b1, 8'h5A, 1'b1, 1'b0});
        chk("post_glitch", nbad, 32'd0);

        // CLK_DIV=1 back-to-back frames
        start_frame(1'b1, 8'h00, 1'b0);
        wait_done(1'b1, 100, lat);
        chk("d1a_lat",  lat,  32'd81);
        chk("d1a_bits", bits, {13'd0, 8'hA0, 1'b1, 8'h00, 1'b1, 1'b0});
        chk("gap_scl",  {31'd0, scl1},  32'd1);
        chk("gap_oe",   {31'd0, oe1},   32'd0);
        chk("gap_busy", {31'd0, busy1}, 32'd0);
        start_frame(1'b1, 8'hFF, 1'b1);
        chk("d1b_busy", {31'd0, busy1}, 32'd1);
        wait_done(1'b1, 100, lat);
        chk("d1b_lat",   lat,   32'd81);
        chk("d1b_bits",  bits,  {13'd0, 8'hA0, 1'b1, 8'hFF, 1'b1, 1'b0});
        chk("d1b_start", nstart, 32'd1);
        chk("d1b_stop",  nstop,  32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
